// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state encodings,
// default widths and small op-decode helpers.
package muldiv_unit_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: shift-add for multiply, restoring shift-subtract for divide.
// The acc:mq pair holds product high:low or remainder:quotient.
module muldiv_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div,
   input  logic [XLEN-1:0] acc_i,
   input  logic [XLEN-1:0] mq_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] acc_o,
   output logic [XLEN-1:0] mq_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            ge;

   always_comb begin
      sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
      shifted = {acc_i, mq_i[XLEN-1]};
      ge      = (shifted >= {1'b0, opnd_i});
      // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
      diff    = shifted[XLEN-1:0] - opnd_i;
      acc_o   = '0;
      mq_o    = '0;
      if (is_div) begin
         acc_o = ge ? diff : shifted[XLEN-1:0];
         mq_o  = {mq_i[XLEN-2:0], ge};
      end else begin
         acc_o = sum[XLEN:1];
         mq_o  = {sum[0], mq_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle,
// magnitude datapath with sign correction in a final FIX cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic            flush,
   input  logic            mthi,
   input  logic            mtlo,
   input  logic [XLEN-1:0] mt_data,
   input  logic            hilo_use,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   mq_q, mq_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              is_div_q, is_div_d;
   logic              neg_lo_q, neg_lo_d;
   logic              neg_hi_q, neg_hi_d;
   logic              dz_q, dz_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              done_q, done_d;
   logic              div_zero_q, div_zero_d;

   logic [XLEN-1:0]   step_acc_c, step_mq_c;
   logic              rs_neg_c, rt_neg_c;
   logic [2*XLEN-1:0] prod_mag_c, prod_fix_c;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (is_div_q),
      .acc_i  (acc_q),
      .mq_i   (mq_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc_c),
      .mq_o   (step_mq_c)
   );

   assign rs_neg_c   = op_is_signed(op) & rs_data[XLEN-1];
   assign rt_neg_c   = op_is_signed(op) & rt_data[XLEN-1];
   assign prod_mag_c = {acc_q, mq_q};
   assign prod_fix_c = neg_lo_q ? -prod_mag_c : prod_mag_c;

   // Next-state, datapath and HI/LO update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mq_d       = mq_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               state_d    = ST_RUN;
               cnt_d      = '0;
               div_zero_d = 1'b0;
               is_div_d   = op_is_div(op);
               acc_d      = '0;
               mq_d       = rs_neg_c ? -rs_data : rs_data;
               opnd_d     = rt_neg_c ? -rt_data : rt_data;
               neg_lo_d   = rs_neg_c ^ rt_neg_c;
               // Remainder follows the dividend; a product negates as one 2*XLEN value.
               neg_hi_d   = op_is_div(op) ? rs_neg_c : (rs_neg_c ^ rt_neg_c);
               dz_d       = op_is_div(op) && (rt_data == '0);
            end else if (!start) begin
               if (mthi) hi_d = mt_data;
               if (mtlo) lo_d = mt_data;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc_c;
               mq_d  = step_mq_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!flush) begin
               done_d     = 1'b1;
               div_zero_d = dz_q;
               if (is_div_q) begin
                  lo_d = dz_q ? '1 : (neg_lo_q ? -mq_q : mq_q);
                  hi_d = neg_hi_q ? -acc_q : acc_q;
               end else begin
                  hi_d = prod_fix_c[2*XLEN-1:XLEN];
                  lo_d = prod_fix_c[XLEN-1:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mq_q       <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mq_q       <= mq_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign stall    = busy & hilo_use;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected HI/LO/div_zero
// filled at launch and drained whenever done pulses.
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        flush, mthi, mtlo;
   logic [31:0] mt_data;
   logic        hilo_use;
   logic        busy, stall, done, div_zero;
   logic [31:0] hi, lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
      .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data), .hilo_use(hilo_use),
      .busy(busy), .stall(stall), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint p;
      int     sa, sb;
      sa = a;
      sb = b;
      e  = '0;
      case (o)
         2'b00: begin p = longint'(sa) * longint'(sb); e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
            end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 32'd0;
            end else if (o == 2'b10) begin
               e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Scoreboard drain: every done pulse must match the oldest outstanding op.
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_done: hi=%h lo=%h with nothing outstanding", hi, lo);
         end else begin
            e = sb_q.pop_front();
            if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
               bad++;
               $display("FAIL sb_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                        hi, lo, div_zero, e.hi, e.lo, e.dz);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the launch edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit completes);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      if (completes) sb_q.push_back(model(o, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total += 5;
      if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz: got %b want 0", div_zero); end
      if (hi !== 32'd0)      begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      if (lo !== 32'd0)      begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      int cyc;
      launch(2'b00, 32'hFFFF_FFFF, 32'd7, 1'b1);
      wait_idle(cyc);
      total++;
      if (cyc !== 33) begin bad++; $display("FAIL mult_latency: got %0d cycles want 33", cyc); end
      total++;
      if (done !== 1'b1) begin bad++; $display("FAIL mult_done_seen: got %b want 1", done); end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_directed();
      int cyc;
      logic [1:0]  ops[5]  = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
      logic [31:0] as[5]   = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs[5]   = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};
      for (int i = 0; i < 5; i++) begin
         launch(ops[i], as[i], bs[i], 1'b1);
         wait_idle(cyc);
         total++;
         if (cyc !== 33) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want 33", i, cyc); end
      end
      @(negedge clk);
   endtask

   task automatic test_div_zero();
      int cyc;
      launch(2'b11, 32'h0000_1234, 32'd0, 1'b1);
      wait_idle(cyc);
      total++;
      if (cyc !== 33) begin bad++; $display("FAIL dz_latency: got %0d want 33", cyc); end
      @(negedge clk);
      total++;
      if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_hold: got %b want 1", div_zero); end
      launch(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1);
      wait_idle(cyc);
      @(negedge clk);
      launch(2'b01, 32'd3, 32'd5, 1'b1);
      total++;
      if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", div_zero); end
      wait_idle(cyc);
      @(negedge clk);
   endtask

   task automatic test_mt();
      int cyc;
      mthi = 1'b1; mt_data = 32'hA;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; mt_data = 32'hB;
      @(negedge clk);
      mtlo = 1'b0;
      total += 2;
      if (hi !== 32'hA) begin bad++; $display("FAIL mt_hi: got %h want a", hi); end
      if (lo !== 32'hB) begin bad++; $display("FAIL mt_lo: got %h want b", lo); end
      mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hC;
      @(negedge clk);
      total += 2;
      if (hi !== 32'hC) begin bad++; $display("FAIL mt_both_hi: got %h want c", hi); end
      if (lo !== 32'hC) begin bad++; $display("FAIL mt_both_lo: got %h want c", lo); end
      mt_data = 32'h55;
      launch(2'b01, 32'd9, 32'd9, 1'b1);
      mthi = 1'b0; mtlo = 1'b0;
      total += 2;
      if (hi !== 32'hC)  begin bad++; $display("FAIL mt_vs_start: got hi=%h want c", hi); end
      if (busy !== 1'b1) begin bad++; $display("FAIL mt_start_wins: got busy=%b want 1", busy); end
      wait_idle(cyc);
      @(negedge clk);
   endtask

   task automatic test_flush();
      mthi = 1'b1; mtlo = 1'b0; mt_data = 32'hA;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b1; mt_data = 32'hB;
      @(negedge clk);
      mtlo = 1'b0;
      launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total += 3;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      if (hi !== 32'hA)  begin bad++; $display("FAIL flush_hi: got %h want a", hi); end
      if (lo !== 32'hB)  begin bad++; $display("FAIL flush_lo: got %h want b", lo); end
      // Flush while in the final sign-fix cycle.
      launch(2'b00, 32'd5, 32'd6, 1'b0);
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_fix_busy: got %b want 0", busy); end
      if (lo !== 32'hB)  begin bad++; $display("FAIL flush_fix_lo: got %h want b", lo); end
      // Flush together with start in IDLE: no launch.
      flush = 1'b1;
      launch(2'b00, 32'd1, 32'd1, 1'b0);
      flush = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_idle: got busy=%b want 0", busy); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      launch(2'b11, 32'd100, 32'd7, 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      total += 3;
      if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      if (hi !== 32'd0)  begin bad++; $display("FAIL rstmid_hi: got %h want 0", hi); end
      if (lo !== 32'd0)  begin bad++; $display("FAIL rstmid_lo: got %h want 0", lo); end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      int cyc;
      launch(2'b00, 32'd6, 32'hFFFF_FFFD, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b11; rs_data = 32'd50; rt_data = 32'd3;
      mtlo = 1'b1; mt_data = 32'hDEAD; hilo_use = 1'b1;
      #1;
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall: got %b want 1", stall); end
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      wait_idle(cyc);
      #1;
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall: got %b want 0", stall); end
      hilo_use = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ignored_start: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      for (int i = 0; i < 10; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'($urandom_range(3, 0));
         a = $urandom;
         b = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(255, 1)) : $urandom);
         launch(o, a, b, 1'b1);
         wait_idle(cyc);
         total++;
         if (cyc !== 33) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 33", i, cyc); end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
      flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; mt_data = '0; hilo_use = 1'b0;
      @(negedge clk);
      test_reset();
      test_mult();
      test_directed();
      test_div_zero();
      test_mt();
      test_flush();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      repeat (2) @(negedge clk);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: %0d results outstanding, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
